chacha_block_sequencer: RTL and testbench
=========================================

Name: chacha_block_sequencer

Overview:
- Controller that turns key/nonce/counter into one 512-bit ChaCha20 keystream block.
- Builds the initial 4x4 state and schedules 80 quarter-rounds (10 double rounds, 8 QRs each) through one shared single-cycle quarter-round unit.
- Adds the initial state back in (feed-forward) and presents the block on a valid/ready interface.
- Sits between the AEAD top and the XOR/Poly1305 key-derivation paths; supports back-to-back blocks with an auto-incremented counter.

Parameters:
- NUM_DOUBLE_ROUNDS, 10, double rounds per block; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a block; accepted only in IDLE.
- key  in  256  byte i at key[8i+7:8i].
- nonce  in  96  byte i at nonce[8i+7:8i].
- counter_in  in  32  initial block counter.
- cont  in  1  sampled on output handshake: chain the next block with counter+1.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  block_out valid.
- out_ready  in  1  consumer accepts block.
- block_out  out  512  word i at [32i+31:32i]; keystream byte j at [8j+7:8j].
- block_ctr  out  32  counter of the block currently on block_out.
- ctr_err  out  1  sticky: chaining refused at counter 0xFFFFFFFF.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; internal state, init copy, qr_idx and dr_cnt cleared. rst wins over every other input; a reset mid-block discards the block with no partial output.
- State words, index i = 4*row + col:
  - w0..w3 = 61707865, 3320646e, 79622d32, 6b206574.
  - w4..w11 = key words (little-endian 32-bit from key bytes 4k..4k+3).
  - w12 = counter.
  - w13..w15 = nonce words.
- FSM states: IDLE, ROUND, ADD, OUT.
- IDLE, start=1: at that edge, init and work state are loaded, ctr_err cleared, qr_idx=0, dr_cnt=0, go to ROUND. start in any other state is ignored.
- ROUND: one QR per cycle on the tuple selected by qr_idx.
  - qr 0..3 (columns): (k, 4+k, 8+k, 12+k).
  - qr 4 = (0,5,10,15), qr 5 = (1,6,11,12), qr 6 = (2,7,8,13), qr 7 = (3,4,9,14).
  - Results are written back to the same four indices at the edge.
  - qr_idx wraps 7 -> 0 and dr_cnt increments on the wrap.
  - At the edge completing qr_idx=7 with dr_cnt = NUM_DOUBLE_ROUNDS-1, go to ADD.
- ADD: block_out[i] = work[i] + init[i], mod 2^32. block_ctr = init w12. out_valid=1. Go to OUT.
- Latency: start sampled at edge N; ROUND covers edges N+1..N+80; out_valid rises after edge N+81.
- OUT: block_out, block_ctr and out_valid held stable until out_valid && out_ready. At the handshake edge:
  - cont=0: go to IDLE, out_valid=0.
  - cont=1 and counter != FFFFFFFF: reload init/work with counter+1 and the same latched key/nonce, go to ROUND, out_valid=0. The next block is valid 81 edges later.
  - cont=1 and counter == FFFFFFFF: no wrap; set ctr_err, go to IDLE.
- A new key/nonce is taken only from IDLE+start; inputs changing mid-block have no effect.
- busy deasserts the cycle after the terminating handshake.

Decomposition:
- Package chacha_pkg:
  - word_t (logic [31:0]).
  - Constants CHACHA_C0..C3.
  - QR index tables QR_A/B/C/D[0:7].
  - FSM enum.
- Sub-module chacha_qround: purely combinational, a,b,c,d in, a',b',c',d' out.
  - a+=b; d^=a; d<<<=16
  - c+=d; b^=c; b<<<=12
  - a+=b; d^=a; d<<<=8
  - c+=d; b^=c; b<<<=7
- The sequencer owns all registers and the index muxing.

Test Plan:
- QR unit alone: a=11111111 b=01020304 c=9b8d6f43 d=01234567 -> a=ea2a92f4 b=cb1cf8ce c=4581472e d=5881c4bb.
- Block vector: key bytes 00..1f, nonce bytes 00 00 00 09 00 00 00 4a 00 00 00 00, counter 1, out_ready=1 -> out_valid exactly 82 cycles after start; block_out bytes 0..15 = 10 f1 e7 e4 d1 3b 59 15 50 0f dd 1f a3 20 71 c4 (word0 = e4e7f110); block_ctr=1.
- Backpressure: out_ready=0 for 20 cycles -> block_out/out_valid stable, busy=1; handshake with cont=1 -> next block_ctr=2, matches the RFC 8439 counter-2 keystream.
- Counter limit: counter_in=FFFFFFFF, cont=1 at handshake -> ctr_err=1, IDLE, no further out_valid; next start clears ctr_err.
- Reset at ROUND cycle 40 -> all outputs 0 next cycle; fresh start produces the correct block.
- start asserted during ROUND and OUT with a different key -> ignored; output matches the original key.

Source files
------------

// File: rtl/chacha_pkg.sv
// chacha_pkg: shared types and constants for the ChaCha20 block sequencer.
//   word_t          32-bit state word
//   CHACHA_C0..C3   "expand 32-byte k" constant words
//   QR_A..QR_D      state indices of the four quarter-round operands, per qr_idx
//                   (0..3 columns, 4..7 diagonals)
//   seq_state_t     sequencer FSM states
package chacha_pkg;

   typedef logic [31:0] word_t;

   localparam word_t CHACHA_C0 = 32'h61707865;
   localparam word_t CHACHA_C1 = 32'h3320646e;
   localparam word_t CHACHA_C2 = 32'h79622d32;
   localparam word_t CHACHA_C3 = 32'h6b206574;

   localparam logic [3:0] QR_A [0:7] = '{4'd0,  4'd1,  4'd2,  4'd3,  4'd0,  4'd1,  4'd2,  4'd3};
   localparam logic [3:0] QR_B [0:7] = '{4'd4,  4'd5,  4'd6,  4'd7,  4'd5,  4'd6,  4'd7,  4'd4};
   localparam logic [3:0] QR_C [0:7] = '{4'd8,  4'd9,  4'd10, 4'd11, 4'd10, 4'd11, 4'd8,  4'd9};
   localparam logic [3:0] QR_D [0:7] = '{4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd12, 4'd13, 4'd14};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_ADD   = 2'd2,
      ST_OUT   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/chacha_qround.sv
// chacha_qround: purely combinational ChaCha20 quarter-round.
//   a, b, c, d     input words
//   qa, qb, qc, qd quarter-round results
module chacha_qround
   import chacha_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   output logic [31:0] qa,
   output logic [31:0] qb,
   output logic [31:0] qc,
   output logic [31:0] qd
);

   word_t a1, b1, c1, d1, a2, b2, c2, d2;

   always_comb begin
      a1 = a + b;
      d1 = d ^ a1;
      d1 = {d1[15:0], d1[31:16]};
      c1 = c + d1;
      b1 = b ^ c1;
      b1 = {b1[19:0], b1[31:20]};
      a2 = a1 + b1;
      d2 = d1 ^ a2;
      d2 = {d2[23:0], d2[31:24]};
      c2 = c1 + d2;
      b2 = b1 ^ c2;
      b2 = {b2[24:0], b2[31:25]};
      qa = a2;
      qb = b2;
      qc = c2;
      qd = d2;
   end

endmodule

// File: rtl/chacha_block_sequencer.sv
// chacha_block_sequencer: produces one 512-bit ChaCha20 keystream block per
// request using a single shared quarter-round unit (one QR per cycle).
//   clk, rst        clock, synchronous active-high reset
//   start           begin a block (honoured only in IDLE)
//   key, nonce      256-bit key / 96-bit nonce, byte i at [8i+7:8i]
//   counter_in      initial block counter
//   cont            sampled at the output handshake: chain next block, counter+1
//   busy            high whenever the FSM is not IDLE
//   out_valid/out_ready  output handshake; transfer when both high at a clk edge,
//                   block_out/block_ctr held stable while out_valid && !out_ready
//   block_out       keystream block, word i at [32i+31:32i]
//   block_ctr       counter value of the block on block_out
//   ctr_err         sticky: chaining refused because the counter would wrap
module chacha_block_sequencer
   import chacha_pkg::*;
#(
   parameter int NUM_DOUBLE_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  counter_in,
   input  logic         cont,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] block_out,
   output logic [31:0]  block_ctr,
   output logic         ctr_err
);

   localparam logic [3:0] LAST_DR = 4'(NUM_DOUBLE_ROUNDS - 1);

   seq_state_t state, state_nxt;

   word_t      init_s [16];
   word_t      work   [16];
   logic [2:0] qr_idx;
   logic [3:0] dr_cnt;

   logic  last_qr;
   logic  handshake;
   logic  ctr_max;
   logic  chain;
   word_t qa, qb, qc, qd;

   assign last_qr   = (qr_idx == 3'd7) && (dr_cnt == LAST_DR);
   assign handshake = (state == ST_OUT) && out_valid && out_ready;
   assign ctr_max   = (init_s[12] == 32'hFFFF_FFFF);
   assign chain     = handshake && cont && !ctr_max;
   assign busy      = (state != ST_IDLE);

   chacha_qround u_qround (
      .a  (work[QR_A[qr_idx]]),
      .b  (work[QR_B[qr_idx]]),
      .c  (work[QR_C[qr_idx]]),
      .d  (work[QR_D[qr_idx]]),
      .qa (qa),
      .qb (qb),
      .qc (qc),
      .qd (qd)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_ROUND;
         ST_ROUND: if (last_qr) state_nxt = ST_ADD;
         ST_ADD:   state_nxt = ST_OUT;
         ST_OUT:   if (handshake) state_nxt = chain ? ST_ROUND : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            init_s[i] <= '0;
            work[i]   <= '0;
         end
         qr_idx    <= '0;
         dr_cnt    <= '0;
         out_valid <= 1'b0;
         block_out <= '0;
         block_ctr <= '0;
         ctr_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  init_s[0] <= CHACHA_C0;
                  init_s[1] <= CHACHA_C1;
                  init_s[2] <= CHACHA_C2;
                  init_s[3] <= CHACHA_C3;
                  work[0]   <= CHACHA_C0;
                  work[1]   <= CHACHA_C1;
                  work[2]   <= CHACHA_C2;
                  work[3]   <= CHACHA_C3;
                  for (int k = 0; k < 8; k++) begin
                     init_s[4+k] <= key[32*k +: 32];
                     work[4+k]   <= key[32*k +: 32];
                  end
                  init_s[12] <= counter_in;
                  work[12]   <= counter_in;
                  for (int k = 0; k < 3; k++) begin
                     init_s[13+k] <= nonce[32*k +: 32];
                     work[13+k]   <= nonce[32*k +: 32];
                  end
                  ctr_err <= 1'b0;
                  qr_idx  <= '0;
                  dr_cnt  <= '0;
               end
            end
            ST_ROUND: begin
               // The four indices of any tuple are distinct, so these writes never collide.
               work[QR_A[qr_idx]] <= qa;
               work[QR_B[qr_idx]] <= qb;
               work[QR_C[qr_idx]] <= qc;
               work[QR_D[qr_idx]] <= qd;
               qr_idx <= qr_idx + 3'd1;
               if (qr_idx == 3'd7) dr_cnt <= dr_cnt + 4'd1;
            end
            ST_ADD: begin
               for (int i = 0; i < 16; i++)
                  block_out[32*i +: 32] <= work[i] + init_s[i];
               block_ctr <= init_s[12];
               out_valid <= 1'b1;
            end
            ST_OUT: begin
               if (handshake) begin
                  out_valid <= 1'b0;
                  if (chain) begin
                     // The init copy already holds key/nonce; only the counter moves.
                     for (int i = 0; i < 16; i++) work[i] <= init_s[i];
                     work[12]   <= init_s[12] + 32'd1;
                     init_s[12] <= init_s[12] + 32'd1;
                     qr_idx     <= '0;
                     dr_cnt     <= '0;
                  end else if (cont) begin
                     ctr_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_block_sequencer.sv
module tb_chacha_block_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [255:0] key;
   logic [95:0]  nonce;
   logic [31:0]  counter_in;
   logic         cont;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] block_out;
   logic [31:0]  block_ctr;
   logic         ctr_err;

   logic [31:0] qa_i, qb_i, qc_i, qd_i, qa_o, qb_o, qc_o, qd_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [511:0] RFC_BLOCK1 = {
      32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
      32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
      32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
      32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

   always #5 clk = ~clk;

   chacha_block_sequencer #(.NUM_DOUBLE_ROUNDS(10)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .nonce(nonce),
      .counter_in(counter_in), .cont(cont), .busy(busy), .out_valid(out_valid),
      .out_ready(out_ready), .block_out(block_out), .block_ctr(block_ctr),
      .ctr_err(ctr_err));

   chacha_qround u_qr (
      .a(qa_i), .b(qb_i), .c(qc_i), .d(qd_i),
      .qa(qa_o), .qb(qb_o), .qc(qc_o), .qd(qd_o));

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference ChaCha20 block (straight RFC 8439 algorithm).
   function automatic logic [127:0] ref_qr(input logic [31:0] a, b, c, d);
      a = a + b; d = d ^ a; d = (d << 16) | (d >> 16);
      c = c + d; b = b ^ c; b = (b << 12) | (b >> 20);
      a = a + b; d = d ^ a; d = (d << 8)  | (d >> 24);
      c = c + d; b = b ^ c; b = (b << 7)  | (b >> 25);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] ctr);
      logic [31:0]  s [16];
      logic [31:0]  x [16];
      logic [127:0] r;
      logic [511:0] res;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
      s[12] = ctr;
      for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
      x = s;
      for (int dr = 0; dr < 10; dr++) begin
         for (int col = 0; col < 4; col++) begin
            r = ref_qr(x[col], x[4+col], x[8+col], x[12+col]);
            {x[col], x[4+col], x[8+col], x[12+col]} = r;
         end
         for (int dg = 0; dg < 4; dg++) begin
            r = ref_qr(x[dg], x[4+(dg+1)%4], x[8+(dg+2)%4], x[12+(dg+3)%4]);
            {x[dg], x[4+(dg+1)%4], x[8+(dg+2)%4], x[12+(dg+3)%4]} = r;
         end
      end
      for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until out_valid is seen after an edge (first counted edge is the next one).
   task automatic wait_valid(input int base, output int cycles);
      cycles = base;
      for (int i = 0; i < 300; i++) begin
         if (out_valid) break;
         tick();
         cycles++;
      end
      check("valid_seen", {511'd0, out_valid}, 512'd1);
   endtask

   logic [255:0] key_a, key_b;
   logic [95:0]  nonce_a;
   logic [511:0] held;
   logic         stable, seen;
   int           cyc;

   initial begin
      for (int i = 0; i < 32; i++) key_a[8*i +: 8] = 8'(i);
      key_b   = ~key_a;
      nonce_a = 96'h00000000_4a000000_09000000;
      rst = 1'b1; start = 1'b0; key = key_a; nonce = nonce_a;
      counter_in = 32'd1; cont = 1'b0; out_ready = 1'b1;
      qa_i = 32'h11111111; qb_i = 32'h01020304; qc_i = 32'h9b8d6f43; qd_i = 32'h01234567;
      tick(); tick();
      check("rst_busy",      {511'd0, busy},      512'd0);
      check("rst_out_valid", {511'd0, out_valid}, 512'd0);
      check("rst_block_out", block_out,           512'd0);
      check("rst_block_ctr", {480'd0, block_ctr}, 512'd0);
      check("rst_ctr_err",   {511'd0, ctr_err},   512'd0);
      rst = 1'b0;
      tick();

      check("qr_a", {480'd0, qa_o}, {480'd0, 32'hea2a92f4});
      check("qr_b", {480'd0, qb_o}, {480'd0, 32'hcb1cf8ce});
      check("qr_c", {480'd0, qc_o}, {480'd0, 32'h4581472e});
      check("qr_d", {480'd0, qd_o}, {480'd0, 32'h5881c4bb});

      // RFC 8439 block vector, single block
      pulse_start();
      check("busy_after_start", {511'd0, busy}, 512'd1);
      wait_valid(1, cyc);
      check("latency", 512'(cyc), 512'd82);
      check("block1", block_out, RFC_BLOCK1);
      check("block1_word0", {480'd0, block_out[31:0]}, {480'd0, 32'he4e7f110});
      check("block1_ctr", {480'd0, block_ctr}, 512'd1);
      tick();
      check("idle_after_hs", {511'd0, busy}, 512'd0);
      check("valid_low_after_hs", {511'd0, out_valid}, 512'd0);

      // Backpressure then chained block
      out_ready = 1'b0; cont = 1'b1;
      pulse_start();
      wait_valid(1, cyc);
      held = block_out; stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (block_out !== held || out_valid !== 1'b1 || busy !== 1'b1) stable = 1'b0;
      end
      check("bp_stable", {511'd0, stable}, 512'd1);
      check("bp_block", held, RFC_BLOCK1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("chain_valid_drop", {511'd0, out_valid}, 512'd0);
      check("chain_busy", {511'd0, busy}, 512'd1);
      wait_valid(0, cyc);
      check("chain_latency", 512'(cyc), 512'd81);
      check("chain_block", block_out, ref_block(key_a, nonce_a, 32'd2));
      check("chain_ctr", {480'd0, block_ctr}, 512'd2);
      cont = 1'b0; out_ready = 1'b1;
      tick();
      check("chain_end_idle", {511'd0, busy}, 512'd0);

      // Counter limit
      counter_in = 32'hFFFF_FFFF; cont = 1'b1;
      pulse_start();
      wait_valid(1, cyc);
      check("max_ctr", {480'd0, block_ctr}, {480'd0, 32'hFFFF_FFFF});
      check("max_block", block_out, ref_block(key_a, nonce_a, 32'hFFFF_FFFF));
      tick();
      check("max_ctr_err", {511'd0, ctr_err}, 512'd1);
      check("max_idle", {511'd0, busy}, 512'd0);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (out_valid || busy) seen = 1'b1;
      end
      check("max_no_more_valid", {511'd0, seen}, 512'd0);
      check("max_err_sticky", {511'd0, ctr_err}, 512'd1);
      counter_in = 32'd5; cont = 1'b0;
      pulse_start();
      check("err_cleared", {511'd0, ctr_err}, 512'd0);
      wait_valid(1, cyc);
      check("ctr5_block", block_out, ref_block(key_a, nonce_a, 32'd5));
      tick();

      // Reset mid-block
      counter_in = 32'd1;
      pulse_start();
      for (int i = 0; i < 40; i++) tick();
      rst = 1'b1;
      tick();
      check("midrst_busy",  {511'd0, busy},      512'd0);
      check("midrst_valid", {511'd0, out_valid}, 512'd0);
      check("midrst_block", block_out,           512'd0);
      check("midrst_ctr",   {480'd0, block_ctr}, 512'd0);
      rst = 1'b0;
      tick();
      pulse_start();
      wait_valid(1, cyc);
      check("post_rst_latency", 512'(cyc), 512'd82);
      check("post_rst_block", block_out, RFC_BLOCK1);
      tick();

      // start ignored while busy, new key/nonce/counter ignored
      counter_in = 32'd7; out_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 10; i++) tick();
      key = key_b; nonce = ~nonce_a; counter_in = 32'd99; start = 1'b1;
      wait_valid(11, cyc);
      for (int i = 0; i < 5; i++) tick();
      start = 1'b0;
      check("ignore_block", block_out, ref_block(key_a, nonce_a, 32'd7));
      check("ignore_ctr", {480'd0, block_ctr}, 512'd7);
      out_ready = 1'b1;
      tick();
      tick();
      check("ignore_idle", {511'd0, busy}, 512'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
